// File: rtl/p22_texv_stepper_pkg.sv
// p22_texv_stepper_pkg: shared FSM state type, half view size and accumulator width for the texv stepper
package p22_texv_stepper_pkg;
  typedef enum logic [1:0] {IDLE, PRE, WALL, POST} state_t;
  localparam int HALF_SIZE = 320;
  localparam int ACC_W = 16;
endpackage

// File: rtl/p22_texv_accum.sv
// p22_texv_accum: wrapping texv accumulator (load vstart on load, add vstep on step, value out)
module p22_texv_accum
  import p22_texv_stepper_pkg::*;
#(
  parameter int W = ACC_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] vstart,
  input  logic [W-1:0] vstep,
  output logic [W-1:0] value
);
  always_ff @(posedge clk)
    if (rst) value <= '0;
    else if (load) value <= vstart;
    else if (step) value <= value + vstep;
endmodule

// File: rtl/p22_texv_stepper.sv
// p22_texv_stepper: walks hpos across a trace line, flags the wall span [half-size, half+size] and steps texv through it; line_start/pixel_en in, hpos/texv/in_wall/line_done and latched line attributes out
module p22_texv_stepper
  import p22_texv_stepper_pkg::*;
#(
  parameter int H_VIEW = 2 * HALF_SIZE,
  parameter int FRAC = ACC_W - 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            line_start,
  input  logic            pixel_en,
  input  logic [10:0]     size,
  input  logic [FRAC+5:0] vstep,
  input  logic [FRAC+5:0] vstart,
  input  logic [1:0]      wall_in,
  input  logic            side_in,
  input  logic [5:0]      texu_in,
  output logic [9:0]      hpos,
  output logic [5:0]      texv,
  output logic [1:0]      wall,
  output logic            side,
  output logic [5:0]      texu,
  output logic [10:0]     size_q,
  output logic            in_wall,
  output logic            line_done
);
  localparam int HALF = H_VIEW / 2;
  localparam int AW = 6 + FRAC;
  localparam logic [9:0] LAST = 10'(H_VIEW - 1);
  state_t state, nxt;
  logic signed [11:0] top_c, top_q, bot_q;
  logic [9:0] hpos_n;
  logic [AW-1:0] vstep_q, acc;
  logic adv;
  assign top_c = 12'(HALF) - {1'b0, size};
  assign hpos_n = hpos + 10'd1;
  assign adv = pixel_en && state != IDLE;
  assign in_wall = state == WALL;
  assign texv = state == WALL ? 6'(acc >> FRAC) : '0;
  always_comb begin
    nxt = state;
    if (line_start) nxt = (top_c <= 12'sd0) ? WALL : PRE;
    else if (adv)
      nxt = (hpos == LAST) ? IDLE
          : (state == PRE && $signed({2'b00, hpos_n}) == top_q) ? WALL
          : (state == WALL && $signed({2'b00, hpos}) == bot_q) ? POST : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      hpos <= '0;
      line_done <= 1'b0;
      wall <= '0;
      side <= 1'b0;
      texu <= '0;
      size_q <= '0;
      top_q <= '0;
      bot_q <= '0;
      vstep_q <= '0;
    end else begin
      state <= nxt;
      line_done <= !line_start && adv && hpos == LAST;
      if (line_start) begin
        hpos <= '0;
        wall <= wall_in;
        side <= side_in;
        texu <= texu_in;
        size_q <= size;
        top_q <= top_c;
        bot_q <= 12'(HALF) + {1'b0, size};
        vstep_q <= vstep;
      end else if (adv && hpos != LAST) hpos <= hpos_n;
    end
  end
  // accumulator holds vstart until the first wall pixel has been shown
  p22_texv_accum #(.W(AW)) u_accum (
    .clk(clk),
    .rst(reset),
    .load(line_start),
    .step(adv && !line_start && state == WALL),
    .vstart(vstart),
    .vstep(vstep_q),
    .value(acc)
  );
endmodule

// File: tb/tb_p22_texv_stepper.sv
// tb_p22_texv_stepper: vector table, corner sequences and random strobes checked against a pixel-index model
module tb_p22_texv_stepper;
  localparam int H = 640;
  localparam int HALF = H / 2;
  logic clk = 1'b0;
  logic reset, line_start, pixel_en;
  logic [10:0] size;
  logic [15:0] vstep, vstart;
  logic [1:0] wall_in;
  logic side_in;
  logic [5:0] texu_in;
  logic [9:0] hpos;
  logic [5:0] texv;
  logic [1:0] wall;
  logic side;
  logic [5:0] texu;
  logic [10:0] size_q;
  logic in_wall, line_done;
  int checks = 0;
  int failures = 0;
  int m_p, m_size, m_vstart, m_vstep, m_wall, m_side, m_texu;
  bit m_act, m_done;
  typedef struct {
    int size;
    int vstart;
    int vstep;
    int probe;
    int iw;
    int tv;
  } vec_t;
  vec_t vecs[18];

  always #5 clk = ~clk;

  p22_texv_stepper dut (
    .clk(clk), .reset(reset), .line_start(line_start), .pixel_en(pixel_en),
    .size(size), .vstep(vstep), .vstart(vstart), .wall_in(wall_in),
    .side_in(side_in), .texu_in(texu_in), .hpos(hpos), .texv(texv),
    .wall(wall), .side(side), .texu(texu), .size_q(size_q),
    .in_wall(in_wall), .line_done(line_done)
  );

  function automatic bit exp_iw(int p);
    return m_act && p >= HALF - m_size && p <= HALF + m_size;
  endfunction

  function automatic int exp_tv(int p);
    int first;
    first = (HALF - m_size < 0) ? 0 : HALF - m_size;
    if (!exp_iw(p)) return 0;
    return ((m_vstart + (p - first) * m_vstep) & 16'hFFFF) >> 10;
  endfunction

  task automatic chk(string n, int a, int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (model pixel %0d)", n, a, e, m_p);
    end
  endtask

  task automatic cyc(bit rs, bit ls, bit pe);
    reset = rs;
    line_start = ls;
    pixel_en = pe;
    if (!ls) begin
      size = 11'($urandom);
      vstart = 16'($urandom);
      vstep = 16'($urandom);
      wall_in = 2'($urandom);
      side_in = 1'($urandom);
      texu_in = 6'($urandom);
    end
    @(posedge clk);
    #1;
    m_done = 0;
    if (rs) begin
      m_act = 0; m_p = 0; m_size = 0; m_vstart = 0; m_vstep = 0;
      m_wall = 0; m_side = 0; m_texu = 0;
    end else if (ls) begin
      m_act = 1; m_p = 0; m_size = size; m_vstart = vstart; m_vstep = vstep;
      m_wall = wall_in; m_side = side_in; m_texu = texu_in;
    end else if (pe && m_act) begin
      if (m_p == H - 1) begin
        m_act = 0;
        m_done = 1;
      end else m_p++;
    end
    chk("hpos", hpos, m_p);
    chk("in_wall", in_wall, exp_iw(m_p));
    chk("texv", texv, exp_tv(m_p));
    chk("line_done", line_done, m_done);
    chk("wall", wall, m_wall);
    chk("side", side, m_side);
    chk("texu", texu, m_texu);
    chk("size_q", size_q, m_size);
  endtask

  task automatic start_line(int s, int vs, int vp, bit rs, bit pe);
    size = 11'(s);
    vstart = 16'(vs);
    vstep = 16'(vp);
    wall_in = 2'($urandom);
    side_in = 1'($urandom);
    texu_in = 6'($urandom);
    cyc(rs, 1'b1, pe);
  endtask

  task automatic run_to(int target);
    for (int n = 0; n < H && m_p != target; n++) cyc(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    vecs = '{
      '{100, 0, 'h400, 219, 0, 0}, '{100, 0, 'h400, 220, 1, 0},
      '{100, 0, 'h400, 221, 1, 1}, '{100, 0, 'h400, 283, 1, 63},
      '{100, 0, 'h400, 284, 1, 0}, '{100, 0, 'h400, 420, 1, 8},
      '{100, 0, 'h400, 421, 0, 0}, '{400, 'h2800, 'h200, 0, 1, 10},
      '{400, 'h2800, 'h200, 2, 1, 11}, '{400, 'h2800, 'h200, 639, 1, 9},
      '{0, 'h1C00, 'h400, 319, 0, 0}, '{0, 'h1C00, 'h400, 320, 1, 7},
      '{0, 'h1C00, 'h400, 321, 0, 0}, '{320, 0, 'h400, 639, 1, 63},
      '{2047, 0, 'h40, 500, 1, 31}, '{319, 'hFC00, 'h400, 0, 0, 0},
      '{319, 'hFC00, 'h400, 1, 1, 63}, '{319, 'hFC00, 'h400, 639, 1, 61}
    };
    reset = 1'b1; line_start = 1'b0; pixel_en = 1'b0;
    size = '0; vstart = '0; vstep = '0; wall_in = '0; side_in = 1'b0; texu_in = '0;
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    start_line(100, 0, 'h400, 1'b1, 1'b1);
    chk("reset_over_start_hpos", hpos, 0);
    cyc(1'b0, 1'b0, 1'b1);
    chk("idle_no_advance", hpos, 0);
    foreach (vecs[i]) begin
      start_line(vecs[i].size, vecs[i].vstart, vecs[i].vstep, 1'b0, 1'b0);
      run_to(vecs[i].probe);
      chk("vec_hpos", hpos, vecs[i].probe);
      chk("vec_in_wall", in_wall, vecs[i].iw);
      chk("vec_texv", texv, vecs[i].tv);
    end
    start_line(400, 'h2800, 'h200, 1'b0, 1'b0);
    run_to(H - 1);
    cyc(1'b0, 1'b0, 1'b1);
    chk("done_pulse", line_done, 1);
    chk("done_hpos", hpos, H - 1);
    cyc(1'b0, 1'b0, 1'b1);
    chk("done_clear", line_done, 0);
    chk("idle_hold", hpos, H - 1);
    start_line(100, 0, 'h400, 1'b0, 1'b0);
    run_to(300);
    start_line(50, 'h1000, 'h100, 1'b0, 1'b1);
    chk("abort_hpos", hpos, 0);
    chk("abort_no_done", line_done, 0);
    chk("abort_size", size_q, 50);
    run_to(H - 1);
    cyc(1'b0, 1'b0, 1'b1);
    start_line(100, 'h3000, 'h400, 1'b0, 1'b0);
    run_to(250);
    chk("midwall_in_wall", in_wall, 1);
    start_line(7, 'h1234, 'h55, 1'b1, 1'b1);
    chk("rst_hpos", hpos, 0);
    chk("rst_texv", texv, 0);
    chk("rst_in_wall", in_wall, 0);
    chk("rst_size_q", size_q, 0);
    chk("rst_texu", texu, 0);
    cyc(1'b0, 1'b0, 1'b1);
    chk("rst_idle", hpos, 0);
    for (int n = 0; n < 12000; n++) begin
      if ((!m_act && $urandom_range(0, 19) == 0) || $urandom_range(0, 1999) == 0) begin
        case ($urandom_range(0, 3))
          0: start_line(0, $urandom, $urandom, 1'b0, 1'($urandom));
          1: start_line($urandom_range(320, 2047), $urandom, $urandom, 1'b0, 1'($urandom));
          2: start_line($urandom_range(0, 319), $urandom, $urandom, 1'b0, 1'($urandom));
          default: start_line($urandom_range(0, 2047), $urandom, $urandom, 1'b0, 1'($urandom));
        endcase
      end else cyc(1'b0, 1'b0, 1'($urandom));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/p22_texv_stepper.md
P22_TEXV_STEPPER -- requirements
Module: p22_texv_stepper

Interface
REQ-001 SHALL have parameter H_VIEW, default 640: trace length in pixels; HALF_SIZE = H_VIEW/2.
REQ-002 SHALL have parameter FRAC, default 10: fractional bits of the V accumulator.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port line_start  input  1  one-cycle pulse that latches the per-line inputs; hpos=0 follows on the next pixel_en.
REQ-006 SHALL have port pixel_en  input  1  advance strobe, one per trace pixel.
REQ-007 SHALL have port size  input  11  half wall height in pixels, 0..2047.
REQ-008 SHALL have port vstep  input  6+FRAC  unsigned texv increment per pixel.
REQ-009 SHALL have port vstart  input  6+FRAC  texv accumulator value at the first wall pixel.
REQ-010 SHALL have ports wall_in (2), side_in (1), texu_in (6)  input  per-line wall attributes.
REQ-011 SHALL have port hpos  output  10  current trace position.
REQ-012 SHALL have port texv  output  6  integer part of the accumulator.
REQ-013 SHALL have ports wall (2), side (1), texu (6), size_q (11)  output  latched per-line attributes for the row-render stage.
REQ-014 SHALL have port in_wall  output  1  high while hpos lies inside the wall span.
REQ-015 SHALL have port line_done  output  1  one-cycle pulse after pixel H_VIEW-1.

Function
REQ-016 SHALL latch size, vstep, vstart, wall_in, side_in, texu_in on line_start; mid-line inputs SHALL be ignored.
REQ-017 SHALL compute top = HALF_SIZE-size and bot = HALF_SIZE+size at 12-bit signed width, once per line, into registers.
REQ-018 SHALL implement FSM states IDLE, PRE, WALL, POST; line_start enters PRE, or WALL when top<=0.
REQ-019 PRE->WALL SHALL occur on the pixel_en where hpos==top; WALL->POST on the pixel_en after hpos==bot; any state->IDLE on the pixel_en at hpos==H_VIEW-1, asserting line_done next cycle.
REQ-020 SHALL reset hpos to 0 on line_start; hpos SHALL increment by 1 per pixel_en while not IDLE and SHALL NOT exceed H_VIEW-1.
REQ-021 SHALL hold the accumulator at vstart through PRE and the first WALL pixel, then add vstep on each WALL pixel_en.
REQ-022 Accumulator addition SHALL wrap modulo 2^(6+FRAC), giving texture repeat.
REQ-023 texv SHALL be 0 in IDLE, PRE and POST; in WALL it SHALL equal accumulator[FRAC+5:FRAC].
REQ-024 hpos, texv and in_wall SHALL be registered and mutually consistent, with 1-cycle latency from pixel_en.
REQ-025 pixel_en low SHALL freeze all state and outputs.
REQ-026 line_start during an active line SHALL abort that line without a line_done pulse and restart per REQ-016/018.
REQ-027 line_start and pixel_en in the same cycle: line_start SHALL win and the pixel_en SHALL be dropped.
REQ-028 size==0 SHALL give a one-pixel wall at hpos==HALF_SIZE; size>=HALF_SIZE SHALL give in_wall high for the entire line.

Reset
REQ-029 On reset: FSM=IDLE; hpos=0; texv=0; in_wall=0; line_done=0; wall=0; side=0; texu=0; size_q=0; accumulator=0.
REQ-030 Reset SHALL take priority over line_start and pixel_en in the same cycle.

Structure
REQ-031 A shared package SHALL hold the FSM state enum, HALF_SIZE, and the accumulator width (6+FRAC).
REQ-032 The accumulator and its wrap logic SHALL be one sub-module, p22_texv_accum (load, step enable, vstep, value).

Verification
REQ-033 size=100, vstep=1.0 (0x0400), vstart=0: in_wall high for hpos 220..420 only; texv=0 at 220, 1 at 221, 63 at 283, 0 at 284.
REQ-034 size=400, vstart=0x2800 (texv 10), vstep=0x0200: in_wall high for hpos 0..639; texv=10 at hpos0, 11 at hpos2; line_done one cycle after hpos 639.
REQ-035 size=0: in_wall high only at hpos 320; texv=vstart integer part there and 0 everywhere else.
REQ-036 pixel_en toggling 1/0 at random: output sequence identical to the continuous-strobe run, with held cycles repeated.
REQ-037 line_start asserted at hpos 300 of a running line: no line_done; hpos=0 next cycle; new attributes latched.
REQ-038 reset asserted mid-WALL together with line_start: every output matches REQ-029 in the next cycle; FSM=IDLE.
